// File: rtl/npu_pkg.sv
// Shared NPU dimensions and the lane state encoding used by the
// controller, the PE array and the result path.
package npu_pkg;

  localparam int NPU_LANES = 8;
  localparam int NPU_ROWS  = 8;
  localparam int NPU_ACC_W = 32;
  localparam int NPU_OUT_W = 8;

  typedef enum logic {
    LANE_EMPTY  = 1'b0,
    LANE_LOADED = 1'b1
  } lane_state_e;

endpackage

// File: rtl/pe_result_lane.sv
// One output lane: snapshots ROWS accumulators as requantized words and
// drains them over a valid/ready port, flagging the last word with rd_eop.
module pe_result_lane
  import npu_pkg::*;
#(
  parameter int ROWS  = NPU_ROWS,
  parameter int ACC_W = NPU_ACC_W,
  parameter int OUT_W = NPU_OUT_W,
  parameter int SHIFT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  save_sop,
  input  logic                  save_finish,
  input  logic [ROWS*ACC_W-1:0] acc,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [OUT_W-1:0]      rd_data,
  output logic                  rd_eop,
  output logic                  loaded,
  output logic                  overrun
);

  localparam int PW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'((64'd1 << SHIFT) >> 1);
  localparam logic signed [ACC_W:0] QMAX = (ACC_W+1)'((64'd1 << (OUT_W-1)) - 64'd1);
  localparam logic signed [ACC_W:0] QMIN = ~QMAX;

  // One extra bit of headroom so the rounding add cannot wrap.
  function automatic logic [OUT_W-1:0] quant(input logic [ACC_W-1:0] a);
    logic signed [ACC_W:0] t;
    t = $signed({a[ACC_W-1], a}) + RND;
    t = t >>> SHIFT;
    if (t > QMAX)      return QMAX[OUT_W-1:0];
    else if (t < QMIN) return QMIN[OUT_W-1:0];
    else               return t[OUT_W-1:0];
  endfunction

  lane_state_e                  state_q, state_d;
  logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [ROWS-1:0][OUT_W-1:0]   mem_q, mem_d;
  logic                         eop_q, eop_d;
  logic                         ovr_q, ovr_d;
  logic                         hs, last;

  always_comb begin
    hs       = (state_q == LANE_LOADED) && save_finish && rd_ready;
    last     = hs && (rd_ptr_q == PW'(ROWS-1));
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    eop_d    = last;
    ovr_d    = ovr_q;
    if (hs) rd_ptr_d = last ? '0 : rd_ptr_q + 1'b1;
    if (last) state_d = LANE_EMPTY;
    // A strobe landing on the final handshake still sees the lane as busy.
    if (save_sop) begin
      if (state_q == LANE_LOADED) begin
        ovr_d = 1'b1;
      end else begin
        state_d  = LANE_LOADED;
        rd_ptr_d = '0;
        for (int r = 0; r < ROWS; r++) mem_d[r] = quant(acc[r*ACC_W +: ACC_W]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LANE_EMPTY;
      rd_ptr_q <= '0;
      mem_q    <= '0;
      eop_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
      eop_q    <= eop_d;
      ovr_q    <= ovr_d;
    end
  end

  assign loaded   = (state_q == LANE_LOADED);
  assign rd_valid = loaded && save_finish;
  assign rd_data  = mem_q[rd_ptr_q];
  assign rd_eop   = eop_q;
  assign overrun  = ovr_q;

endmodule

// File: rtl/pe_result_cache.sv
// Per-lane result buffers between the PE array and the result writer;
// each lane drains independently and busy covers any lane still loaded.
module pe_result_cache
  import npu_pkg::*;
#(
  parameter int LANES = NPU_LANES,
  parameter int ROWS  = NPU_ROWS,
  parameter int ACC_W = NPU_ACC_W,
  parameter int OUT_W = NPU_OUT_W,
  parameter int SHIFT = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        save_sop,
  input  logic                        save_finish,
  input  logic [LANES*ROWS*ACC_W-1:0] pe_result,
  input  logic [LANES-1:0]            rd_ready,
  output logic [LANES-1:0]            rd_valid,
  output logic [LANES*OUT_W-1:0]      rd_data,
  output logic [LANES-1:0]            rd_eop,
  output logic                        busy,
  output logic [LANES-1:0]            overrun
);

  logic [LANES-1:0] loaded;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pe_result_lane #(
      .ROWS  (ROWS),
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .save_sop    (save_sop),
      .save_finish (save_finish),
      .acc         (pe_result[l*ROWS*ACC_W +: ROWS*ACC_W]),
      .rd_ready    (rd_ready[l]),
      .rd_valid    (rd_valid[l]),
      .rd_data     (rd_data[l*OUT_W +: OUT_W]),
      .rd_eop      (rd_eop[l]),
      .loaded      (loaded[l]),
      .overrun     (overrun[l])
    );
  end

  assign busy = |loaded;

endmodule

// File: tb/tb_pe_result_cache.sv
// Directed scenarios plus random traffic against a queue-based lane model.
module tb_pe_result_cache;
  localparam int LANES = 8, ROWS = 8, ACC_W = 32, OUT_W = 8, SHIFT = 8;

  logic                        clk = 1'b0;
  logic                        rst, save_sop, save_finish, busy;
  logic [LANES*ROWS*ACC_W-1:0] pe;
  logic [LANES-1:0]            rd_ready, rd_valid, rd_eop, overrun;
  logic [LANES*OUT_W-1:0]      rd_data;

  always #5 clk = ~clk;

  pe_result_cache #(.LANES(LANES), .ROWS(ROWS), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .save_sop(save_sop), .save_finish(save_finish), .pe_result(pe),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_eop(rd_eop),
    .busy(busy), .overrun(overrun));

  int checks = 0, failures = 0, rel = 0;
  int eop_at[LANES];
  logic [OUT_W-1:0] mq[LANES][$];
  bit m_eop[LANES], m_ovr[LANES];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Round half up, floor-shift, clamp to the signed output range.
  function automatic logic [OUT_W-1:0] qref(input logic [ACC_W-1:0] a);
    longint v;
    v = longint'($signed(a));
    v = v + (longint'(1) << SHIFT) / 2;
    v = v >>> SHIFT;
    if (v > (longint'(1) << (OUT_W-1)) - 1) v = (longint'(1) << (OUT_W-1)) - 1;
    if (v < -(longint'(1) << (OUT_W-1)))    v = -(longint'(1) << (OUT_W-1));
    return v[OUT_W-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] lane_data(input int l);
    return rd_data[l*OUT_W +: OUT_W];
  endfunction

  task automatic model_step();
    if (rst) begin
      for (int l = 0; l < LANES; l++) begin
        mq[l].delete(); m_eop[l] = 0; m_ovr[l] = 0;
      end
    end else begin
      for (int l = 0; l < LANES; l++) begin
        bit ld, hs;
        ld = mq[l].size() != 0;
        hs = ld && save_finish && rd_ready[l];
        m_eop[l] = hs && mq[l].size() == 1;
        if (hs) void'(mq[l].pop_front());
        if (save_sop) begin
          if (ld) m_ovr[l] = 1;
          else for (int r = 0; r < ROWS; r++) mq[l].push_back(qref(pe[(l*ROWS+r)*ACC_W +: ACC_W]));
        end
      end
    end
  endtask

  // Called at a negedge with inputs set: check, clock, update model.
  task automatic tick();
    logic [LANES-1:0] ev, ee, eo;
    logic eb;
    #1;
    eb = 0;
    for (int l = 0; l < LANES; l++) begin
      ev[l] = (mq[l].size() != 0) && save_finish;
      ee[l] = m_eop[l];
      eo[l] = m_ovr[l];
      eb |= mq[l].size() != 0;
    end
    chk("rd_valid", rd_valid, ev);
    chk("rd_eop", rd_eop, ee);
    chk("overrun", overrun, eo);
    chk("busy", busy, eb);
    for (int l = 0; l < LANES; l++) begin
      if (ev[l]) chk($sformatf("rd_data%0d", l), lane_data(l), mq[l][0]);
      if (rd_eop[l] && eop_at[l] < 0) eop_at[l] = rel;
    end
    @(posedge clk);
    model_step();
    rel++;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic save();
    save_sop = 1; rel = 0;
    for (int l = 0; l < LANES; l++) eop_at[l] = -1;
    tick();
    save_sop = 0;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < LANES*ROWS; i++) pe[i*ACC_W +: ACC_W] = ACC_W'(i << 8);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < LANES*ROWS; i++)
      if ($urandom_range(0, 1) == 0) pe[i*ACC_W +: ACC_W] = $urandom;
      else pe[i*ACC_W +: ACC_W] = ACC_W'(int'($urandom_range(0, 80000)) - 40000);
  endtask

  initial begin
    logic [OUT_W-1:0] qexp[5];
    qexp = '{8'h01, 8'h00, 8'h00, 8'h7F, 8'h80};
    for (int l = 0; l < LANES; l++) eop_at[l] = -1;
    rst = 1; save_sop = 0; save_finish = 0; rd_ready = '0; pe = '0;
    repeat (2) @(posedge clk);
    model_step();
    @(negedge clk);
    rst = 0;

    // Reset state and basic drain
    save_finish = 1; rd_ready = '1;
    ticks(2);
    fill_ramp();
    save();
    ticks(8);
    chk("eop_all_t9", rd_eop, {LANES{1'b1}});
    chk("busy_t9", busy, 0);
    ticks(2);

    // Backpressure on lane 3
    save();
    for (int k = 1; k <= 20; k++) begin
      rd_ready[3] = k[0];
      tick();
    end
    rd_ready = '1;
    chk("eop3_cycle", eop_at[3], 16);
    chk("eop0_cycle", eop_at[0], 9);
    chk("eop7_cycle", eop_at[7], 9);

    // Enable gating and quantization vectors on lane 0
    fill_rand();
    pe[0*ACC_W +: ACC_W] = 32'h0000_0080;
    pe[1*ACC_W +: ACC_W] = 32'h0000_007F;
    pe[2*ACC_W +: ACC_W] = 32'hFFFF_FF80;
    pe[3*ACC_W +: ACC_W] = 32'h0001_0000;
    pe[4*ACC_W +: ACC_W] = 32'hFFFF_0000;
    save_finish = 0;
    save();
    for (int k = 0; k < 5; k++) begin
      chk("gated_valid", rd_valid, 0);
      tick();
    end
    save_finish = 1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("quant%0d", k), lane_data(0), qexp[k]);
      tick();
    end
    ticks(5);

    // save_finish dropped after word 2
    fill_ramp();
    save();
    ticks(3);
    save_finish = 0;
    ticks(3);
    save_finish = 1;
    chk("resume_word3", lane_data(2), 8'd19);
    ticks(7);

    // Overrun: second strobe while lane 0 has 4 words left
    rd_ready = {{(LANES-1){1'b1}}, 1'b0};
    save();
    ticks(4);
    rd_ready = '1;
    ticks(4);
    fill_rand();
    save_sop = 1;
    tick();
    save_sop = 0;
    ticks(12);
    chk("overrun_lane0", overrun, 1);

    // Reset mid-drain
    fill_ramp();
    save();
    ticks(5);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_valid", rd_valid, 0);
    chk("rst_eop", rd_eop, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    save();
    chk("fresh_word0", lane_data(5), 8'd40);
    ticks(10);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      save_sop = ($urandom_range(0, 9) == 0);
      save_finish = ($urandom_range(0, 3) != 0);
      rd_ready = LANES'($urandom);
      if (save_sop) fill_rand();
      tick();
    end
    rst = 0; save_sop = 0; save_finish = 1; rd_ready = '1;
    ticks(12);
    chk("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
